btn_press_gen: RTL

//  Button-press waveform generator: converts a one-cycle event request (single tap, double tap,

---
 rtl/btn_press_gen_pkg.sv | 26 ++
 rtl/btn_press_gen_if.sv | 22 ++
 rtl/btn_press_gen_us_tick_gen.sv | 27 ++
 rtl/btn_press_gen.sv | 117 +++++++++++
 4 files changed

// File: rtl/btn_press_gen_pkg.sv
// Shared definitions for the button-press waveform generator: one-hot FSM states,
// event kinds and phase counter width.
package btn_press_gen_pkg;

  localparam int US_CNT_W = 21;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_PRESS1 = 5'b00010,
    ST_GAP    = 5'b00100,
    ST_PRESS2 = 5'b01000,
    ST_GUARD  = 5'b10000
  } state_e;

  typedef enum logic [1:0] {
    EV_SINGLE = 2'd0,
    EV_DOUBLE = 2'd1,
    EV_LONG   = 2'd2
  } ev_kind_e;

  // Terminal count of the us counter for a phase lasting n microseconds.
  function automatic logic [US_CNT_W-1:0] us_last(input int unsigned n);
    return US_CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/btn_press_gen_if.sv
// Request/response bundle between an event requester (master) and the press generator (slave).
interface btn_press_gen_if;

  logic req_single;
  logic req_double;
  logic req_long;
  logic cancel;
  logic btn_out;
  logic busy;
  logic done;

  modport master (
    output req_single, req_double, req_long, cancel,
    input  btn_out, busy, done
  );

  modport slave (
    input  req_single, req_double, req_long, cancel,
    output btn_out, busy, done
  );

endinterface

// File: rtl/btn_press_gen_us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US clocks, restartable by a sync clear.
module us_tick_gen #(
  parameter int unsigned CLK_PER_US = 125
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [PW-1:0] presc_q, presc_d;

  assign tick_o = (presc_q == PW'(CLK_PER_US - 1));

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (clr_i || tick_o) presc_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

endmodule

// File: rtl/btn_press_gen.sv
// Button-press waveform generator: turns a one-cycle single/double/long request into a
// timed active-high button level, followed by a mandatory release guard and a done pulse.
module btn_press_gen
  import btn_press_gen_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 125,
  parameter int unsigned SHORT_US   = 100_000,
  parameter int unsigned LONG_US    = 1_000_000,
  parameter int unsigned GAP_US     = 50_000,
  parameter int unsigned GUARD_US   = 200_000
) (
  input logic            clk,
  input logic            reset_n,
  btn_press_gen_if.slave bus
);

  state_e              state_q, state_d;
  ev_kind_e            ev_q, ev_d;
  logic [US_CNT_W-1:0] us_q, us_d, us_end;
  logic                tick, clr, phase_end;
  logic                btn_out_q, btn_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (clr),
    .tick_o (tick)
  );

  always_comb begin
    us_end = us_last(GUARD_US);
    case (state_q)
      ST_PRESS1: us_end = (ev_q == EV_LONG) ? us_last(LONG_US) : us_last(SHORT_US);
      ST_GAP:    us_end = us_last(GAP_US);
      ST_PRESS2: us_end = us_last(SHORT_US);
      default:   ;
    endcase
  end

  assign phase_end = tick && (us_q == us_end);

  always_comb begin
    state_d = state_q;
    ev_d    = ev_q;
    case (state_q)
      ST_IDLE: begin
        // The done cycle still counts as part of the finished event.
        if (!done_q) begin
          if (bus.req_long) begin
            ev_d    = EV_LONG;
            state_d = ST_PRESS1;
          end else if (bus.req_double) begin
            ev_d    = EV_DOUBLE;
            state_d = ST_PRESS1;
          end else if (bus.req_single) begin
            ev_d    = EV_SINGLE;
            state_d = ST_PRESS1;
          end
        end
      end
      ST_PRESS1: begin
        if (bus.cancel)     state_d = ST_GUARD;
        else if (phase_end) state_d = (ev_q == EV_DOUBLE) ? ST_GAP : ST_GUARD;
      end
      ST_GAP: begin
        if (bus.cancel)     state_d = ST_GUARD;
        else if (phase_end) state_d = ST_PRESS2;
      end
      ST_PRESS2: begin
        if (bus.cancel)     state_d = ST_GUARD;
        else if (phase_end) state_d = ST_GUARD;
      end
      ST_GUARD: begin
        if (phase_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Restarting timing on every state entry makes each phase exactly N*CLK_PER_US cycles.
  assign clr = (state_d != state_q) || (state_q == ST_IDLE);

  always_comb begin
    us_d = us_q;
    if (clr)       us_d = '0;
    else if (tick) us_d = us_q + US_CNT_W'(1);
  end

  assign btn_out_d = (state_d == ST_PRESS1) || (state_d == ST_PRESS2);
  assign busy_d    = (state_d != ST_IDLE);
  assign done_d    = (state_q == ST_GUARD) && (state_d == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ev_q      <= EV_SINGLE;
      us_q      <= '0;
      btn_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ev_q      <= ev_d;
      us_q      <= us_d;
      btn_out_q <= btn_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.btn_out = btn_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
